// File: rtl/mips_pkg.sv
// Shared types and constants for the mips_core instruction-fetch front end.
package mips_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
    localparam int PC_STEP = 4;
    localparam int DEFAULT_ADDR_W = 32;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] pc;
        logic [INST_W-1:0]         inst;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Synchronous first-word-fall-through queue of fetched {pc, inst} entries.
module mips_fetch_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  entry_t                     wr_data,
    output entry_t                     rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    entry_t         mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst_b || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_data;
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count   = CNT_W'(wr_ptr - rd_ptr);
    assign rd_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch front end: owns the PC, drives instruction memory and queues
// fetched instructions for decode with redirect, halt and back-pressure.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_b,
    output logic [ADDR_W-1:0]          inst_addr,
    input  logic [INST_W-1:0]          inst,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       halt_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_W-1:0]          out_inst,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pc_plus4,
    output logic                       align_err,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_slot_t;

    logic [ADDR_W-1:0] pc;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    fetch_slot_t       wr_entry;
    fetch_slot_t       head;

    assign pop = out_valid && out_ready;

    // A full queue still fetches when the head leaves, keeping 1 inst/cycle.
    assign push = !halted && !halt_req && !redirect_valid && (!full || pop);

    assign wr_entry.pc   = pc;
    assign wr_entry.inst = inst;

    mips_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_slot_t)
    ) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            pc        <= RESET_PC;
            halted    <= 1'b0;
            align_err <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (push) begin
                pc <= pc + ADDR_W'(PC_STEP);
            end
            halted    <= halted || halt_req;
            align_err <= redirect_valid && (|redirect_pc[1:0]);
        end
    end

    assign inst_addr    = pc;
    assign out_valid    = !empty;
    assign out_inst     = empty ? NOP_INST : head.inst;
    assign out_pc       = empty ? '0 : head.pc;
    assign out_pc_plus4 = out_pc + ADDR_W'(PC_STEP);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: directed vectors, one DUT at RESET_PC=0
// and one at RESET_PC=0xFFFF_FFF8 for the address wrap.
module tb_mips_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    int          vectors;
    int          miscompares;
    exp_t        exp0 [$];
    exp_t        exp1 [$];

    logic        rst0, redir_valid0, halt0, ready0;
    logic [31:0] redir_pc0;
    logic [31:0] inst_addr0, inst0, out_inst0, out_pc0, out_plus0;
    logic        out_valid0, align_err0, halted0;
    logic [2:0]  count0;

    logic        rst1, redir_valid1, halt1, ready1;
    logic [31:0] redir_pc1;
    logic [31:0] inst_addr1, inst1, out_inst1, out_pc1, out_plus1;
    logic        out_valid1, align_err1, halted1;
    logic [2:0]  count1;

    assign inst0 = inst_addr0 | 32'hA000_0000;
    assign inst1 = inst_addr1 | 32'hA000_0000;

    mips_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut0 (
        .clk(clk), .rst_b(rst0), .inst_addr(inst_addr0), .inst(inst0),
        .redirect_valid(redir_valid0), .redirect_pc(redir_pc0), .halt_req(halt0),
        .out_valid(out_valid0), .out_ready(ready0), .out_inst(out_inst0),
        .out_pc(out_pc0), .out_pc_plus4(out_plus0), .align_err(align_err0),
        .halted(halted0), .count(count0)
    );

    mips_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut1 (
        .clk(clk), .rst_b(rst1), .inst_addr(inst_addr1), .inst(inst1),
        .redirect_valid(redir_valid1), .redirect_pc(redir_pc1), .halt_req(halt1),
        .out_valid(out_valid1), .out_ready(ready1), .out_inst(out_inst1),
        .out_pc(out_pc1), .out_pc_plus4(out_plus1), .align_err(align_err1),
        .halted(halted1), .count(count1)
    );

    always #5 clk = ~clk;

    // Monitor: every handshake on either DUT must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid0 && ready0) begin
            vectors++;
            if (exp0.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL sb0_extra: got pc %0h inst %0h, want no pop", out_pc0, out_inst0);
            end else begin
                e = exp0.pop_front();
                if (out_pc0 !== e.pc || out_inst0 !== e.inst || out_plus0 !== e.pc + 32'd4) begin
                    miscompares++;
                    $display("[TB] FAIL sb0_pop: got pc %0h inst %0h plus4 %0h, want pc %0h inst %0h plus4 %0h",
                             out_pc0, out_inst0, out_plus0, e.pc, e.inst, e.pc + 32'd4);
                end
            end
        end
        if (out_valid1 && ready1) begin
            vectors++;
            if (exp1.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL sb1_extra: got pc %0h inst %0h, want no pop", out_pc1, out_inst1);
            end else begin
                e = exp1.pop_front();
                if (out_pc1 !== e.pc || out_inst1 !== e.inst || out_plus1 !== e.pc + 32'd4) begin
                    miscompares++;
                    $display("[TB] FAIL sb1_pop: got pc %0h inst %0h plus4 %0h, want pc %0h inst %0h plus4 %0h",
                             out_pc1, out_inst1, out_plus1, e.pc, e.inst, e.pc + 32'd4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic ready, input logic rv,
                                 input logic [31:0] rpc, input logic halt);
        rst0         = rst;
        ready0       = ready;
        redir_valid0 = rv;
        redir_pc0    = rpc;
        halt0        = halt;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic expect0(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = pc | 32'hA000_0000;
        exp0.push_back(e);
    endtask

    task automatic expect1(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = pc | 32'hA000_0000;
        exp1.push_back(e);
    endtask

    initial begin
        clk = 0; vectors = 0; miscompares = 0;
        rst0 = 1; ready0 = 0; redir_valid0 = 0; redir_pc0 = 0; halt0 = 0;
        rst1 = 1; ready1 = 0; redir_valid1 = 0; redir_pc1 = 0; halt1 = 0;

        // Reset state and streaming at one instruction per cycle.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_count", 32'(count0), 0);
        checkOutput("rst_valid", 32'(out_valid0), 0);
        checkOutput("rst_halted", 32'(halted0), 0);
        checkOutput("rst_align", 32'(align_err0), 0);
        checkOutput("rst_addr", inst_addr0, 32'h0);
        checkOutput("rst_inst", out_inst0, 32'h0);
        checkOutput("rst_pc", out_pc0, 32'h0);
        checkOutput("rst_plus4", out_plus0, 32'h4);
        expect0(32'h0); expect0(32'h4); expect0(32'h8); expect0(32'hC);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("stream_count", 32'(count0), 1);
        end

        // Back-pressure fills the queue, then drains with no bubble.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("full_count", 32'(count0), 4);
        checkOutput("full_addr", inst_addr0, 32'h10);
        checkOutput("full_head", out_pc0, 32'h0);
        expect0(32'h0); expect0(32'h4); expect0(32'h8); expect0(32'hC); expect0(32'h10);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("drain_count", 32'(count0), 4);
            checkOutput("drain_valid", 32'(out_valid0), 1);
        end
        checkOutput("drain_head", out_pc0, 32'h14);

        // Misaligned redirect flushes three entries.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pre_redir_count", 32'(count0), 3);
        applyStimulus(0, 0, 1, 32'h0000_0102, 0);
        checkOutput("redir_count", 32'(count0), 0);
        checkOutput("redir_addr", inst_addr0, 32'h100);
        checkOutput("redir_align", 32'(align_err0), 1);
        checkOutput("redir_valid", 32'(out_valid0), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("redir_align_pulse", 32'(align_err0), 0);
        checkOutput("redir_new_count", 32'(count0), 1);
        checkOutput("redir_new_pc", out_pc0, 32'h100);
        expect0(32'h100);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("redir_next_pc", out_pc0, 32'h104);

        // Address wrap on the second DUT.
        rst0 = 1; ready0 = 0;
        rst1 = 1; tick();
        checkOutput("wrap_rst_addr", inst_addr1, 32'hFFFF_FFF8);
        expect1(32'hFFFF_FFF8); expect1(32'hFFFF_FFFC); expect1(32'h0); expect1(32'h4);
        rst1 = 0; ready1 = 1;
        for (int i = 0; i < 5; i++) tick();
        ready1 = 0;
        tick();

        // Halt drains exactly the two queued entries, redirect does not resume.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("halt_pre_count", 32'(count0), 2);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("halt_set", 32'(halted0), 1);
        checkOutput("halt_count", 32'(count0), 2);
        checkOutput("halt_addr", inst_addr0, 32'h8);
        expect0(32'h0); expect0(32'h4);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("halt_drained", 32'(count0), 0);
        checkOutput("halt_addr_hold", inst_addr0, 32'h8);
        applyStimulus(0, 1, 1, 32'h40, 0);
        checkOutput("halt_redir_addr", inst_addr0, 32'h40);
        checkOutput("halt_redir_count", 32'(count0), 0);
        checkOutput("halt_redir_align", 32'(align_err0), 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("halt_stay_count", 32'(count0), 0);
        checkOutput("halt_stay_valid", 32'(out_valid0), 0);
        checkOutput("halt_sticky", 32'(halted0), 1);

        // Reset overrides a simultaneous redirect and halt on a full queue.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ovr_pre_count", 32'(count0), 4);
        applyStimulus(1, 0, 1, 32'h203, 1);
        checkOutput("ovr_addr", inst_addr0, 32'h0);
        checkOutput("ovr_count", 32'(count0), 0);
        checkOutput("ovr_align", 32'(align_err0), 0);
        checkOutput("ovr_halted", 32'(halted0), 0);
        checkOutput("ovr_valid", 32'(out_valid0), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ovr_resume_count", 32'(count0), 1);

        checkOutput("sb0_drained", 32'(exp0.size()), 0);
        checkOutput("sb1_drained", 32'(exp1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
